// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receive demultiplexer.
// Collects four serial WIDTH-bit beats (slot 0..3, sync marks slot 0) into
// shadow registers and publishes them as one registered parallel frame.
// Optional build macro TDM_SYNC_CHECK_EN: checks sync on every locked beat,
// realigning or dropping lock on a mismatch and pulsing sync_err.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] ch_a,
  output logic [WIDTH-1:0] ch_b,
  output logic [WIDTH-1:0] ch_c,
  output logic [WIDTH-1:0] ch_d,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic [WIDTH-1:0] cha_q, cha_d, chb_q, chb_d, chc_q, chc_d, chd_q, chd_d;
  logic             fv_q, fv_d;
  logic             serr_q, serr_d;

  // State, shadow and output registers; reset drops any partial frame and lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sha_q   <= '0;
      shb_q   <= '0;
      shc_q   <= '0;
      cha_q   <= '0;
      chb_q   <= '0;
      chc_q   <= '0;
      chd_q   <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      cha_q   <= cha_d;
      chb_q   <= chb_d;
      chc_q   <= chc_d;
      chd_q   <= chd_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
    end
  end

  // Next-state: hunt for sync, then place beats by slot counter; slot 3 publishes.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shc_d   = shc_q;
    cha_d   = cha_q;
    chb_d   = chb_q;
    chc_d   = chc_q;
    chd_d   = chd_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (sync) begin
          sha_d   = din;
          slot_d  = 2'd1;
          state_d = LOCKED;
        end
`ifdef TDM_SYNC_CHECK_EN
      end else if (sync && (slot_q != 2'd0)) begin
        // Early sync: restart the frame on this beat, discarding the partial one.
        serr_d = 1'b1;
        sha_d  = din;
        slot_d = 2'd1;
      end else if (!sync && (slot_q == 2'd0)) begin
        // Missing sync: lock is lost, beat discarded.
        serr_d  = 1'b1;
        state_d = HUNT;
        slot_d  = 2'd0;
`endif
      end else begin
        case (slot_q)
          2'd0: sha_d = din;
          2'd1: shb_d = din;
          2'd2: shc_d = din;
          default: begin
            cha_d = sha_q;
            chb_d = shb_q;
            chc_d = shc_q;
            chd_d = din;
            fv_d  = 1'b1;
          end
        endcase
        slot_d = slot_q + 2'd1;
      end
    end
  end

  assign ch_a        = cha_q;
  assign ch_b        = chb_q;
  assign ch_c        = chc_q;
  assign ch_d        = chd_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = serr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=4); expectations follow the build macro.
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] ch_a, ch_b, ch_c, ch_d;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d),
    .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted beat; outputs are sampled 1 time unit after the edge.
  task automatic beat(input logic [W-1:0] d, input logic s);
    @(negedge clk);
    din = d; din_valid = 1'b1; sync = s;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chs();
    return {16'h0, ch_a, ch_b, ch_c, ch_d};
  endfunction

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
    #1;
    check("reset_ch", chs(), 32'h0);
    check("reset_slot", slot, 0);
    check("reset_locked", locked, 0);
    check("reset_fv", frame_valid, 0);
    check("reset_serr", sync_err, 0);
    @(negedge clk); rst = 1'b0;

    // Hunt: non-sync beats dropped, then lock on sync.
    beat(4'h5, 1'b0); check("hunt_drop5_locked", locked, 0); check("hunt_drop5_slot", slot, 0);
    beat(4'h6, 1'b0); check("hunt_drop6_locked", locked, 0);
    beat(4'h1, 1'b1); check("lock_locked", locked, 1); check("lock_slot", slot, 1);
    check("lock_fv", frame_valid, 0);
    beat(4'h2, 1'b0); check("lock_slot2", slot, 2);
    beat(4'h3, 1'b0); check("lock_slot3", slot, 3); check("lock_fv3", frame_valid, 0);
    beat(4'h4, 1'b0); check("frame1_fv", frame_valid, 1); check("frame1_ch", chs(), 32'h1234);
    check("frame1_slot", slot, 0);
    idle(1); check("frame1_fv_drop", frame_valid, 0); check("frame1_hold", chs(), 32'h1234);

    // Back-to-back frames with a 2-cycle gap inside the first one.
    beat(4'hA, 1'b1); beat(4'hB, 1'b0);
    idle(2); check("gap_fv", frame_valid, 0); check("gap_slot", slot, 2);
    check("gap_hold", chs(), 32'h1234);
    beat(4'hC, 1'b0); beat(4'hD, 1'b0);
    check("frameA_fv", frame_valid, 1); check("frameA_ch", chs(), 32'hABCD);
    beat(4'h0, 1'b1); check("frameB_b0_fv", frame_valid, 0);
    beat(4'hF, 1'b0); beat(4'h7, 1'b0);
    check("frameB_hold", chs(), 32'hABCD); check("frameB_b2_fv", frame_valid, 0);
    beat(4'h8, 1'b0); check("frameB_fv", frame_valid, 1); check("frameB_ch", chs(), 32'h0F78);

    // Wrap: three frames, slot counts 1,2,3,0 after each beat, no sync errors.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        beat(W'(f + i), i == 0);
        check("wrap_slot", slot, (i + 1) % 4);
        check("wrap_serr", sync_err, 0);
        check("wrap_fv", frame_valid, i == 3);
      end
    end

    // Misaligned sync: 1(sync),2 then 9(sync).
    beat(4'h1, 1'b1); beat(4'h2, 1'b0);
    beat(4'h9, 1'b1);
`ifdef TDM_SYNC_CHECK_EN
    check("mis_serr", sync_err, 1); check("mis_fv", frame_valid, 0); check("mis_slot", slot, 1);
    beat(4'h3, 1'b0); check("mis_serr_clr", sync_err, 0);
    beat(4'h4, 1'b0);
    beat(4'h5, 1'b0); check("mis_fv2", frame_valid, 1); check("mis_ch", chs(), 32'h9345);
`else
    check("mis_serr", sync_err, 0); check("mis_slot", slot, 3);
    beat(4'h3, 1'b0); check("mis_fv", frame_valid, 1); check("mis_ch", chs(), 32'h1293);
    beat(4'h4, 1'b0);
    beat(4'h5, 1'b0); check("mis_slot2", slot, 2);
    beat(4'h6, 1'b0);
    beat(4'h7, 1'b0); check("mis_fv2", frame_valid, 1); check("mis_ch2", chs(), 32'h4567);
`endif
    check("mis_slot_end", slot, 0);

    // Lost sync: full frame, then slot-0 beat without sync.
    beat(4'h1, 1'b1); beat(4'h2, 1'b0); beat(4'h3, 1'b0); beat(4'h4, 1'b0);
    check("lost_frame_ch", chs(), 32'h1234);
    beat(4'h5, 1'b0);
`ifdef TDM_SYNC_CHECK_EN
    check("lost_serr", sync_err, 1); check("lost_locked", locked, 0); check("lost_slot", slot, 0);
    beat(4'h6, 1'b0); check("lost_ignore_locked", locked, 0); check("lost_ignore_slot", slot, 0);
    check("lost_serr_clr", sync_err, 0);
    beat(4'h7, 1'b1); check("relock_locked", locked, 1); check("relock_slot", slot, 1);
`else
    check("lost_serr", sync_err, 0); check("lost_locked", locked, 1); check("lost_slot", slot, 1);
    beat(4'h6, 1'b0); check("lost_slot2", slot, 2);
    beat(4'h7, 1'b1); check("lost_sync_ignored", slot, 3); check("lost_serr2", sync_err, 0);
`endif

    // Asynchronous reset mid-frame, between clock edges.
    #2 rst = 1'b1;
    #1;
    check("arst_ch", chs(), 32'h0);
    check("arst_slot", slot, 0);
    check("arst_locked", locked, 0);
    check("arst_fv", frame_valid, 0);
    check("arst_serr", sync_err, 0);
    @(negedge clk); rst = 1'b0;
    idle(1); check("arst_hold_ch", chs(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
